data_mem_master: RTL
====================

Name: data_mem_master

Overview:
- Initiator side of the data-memory port: a multi-cycle load/store controller.
- Accepts one CPU request at a time (load or store; byte, halfword or word).
- Drives the word-only data memory through Address/writeData/MemRead/MemWrite/ReadData.
- Sub-word stores use read-modify-write; sub-word loads are extracted and sign- or zero-extended.

Parameters:
RD_LAT, 1, cycles MemRead/Address held before ReadData is sampled (1..4)
ADDR_W, 32, address width

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
Req  in  1  request strobe, sampled only in IDLE
ReqWrite  in  1  1=store, 0=load
ReqSize  in  2  00=byte, 01=half, 10=word, 11=illegal
ReqSigned  in  1  load sign-extend (1) / zero-extend (0); ignored for stores
ReqAddr  in  ADDR_W  byte address
ReqWData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
Busy  out  1  request in progress (not IDLE)
Done  out  1  one-cycle completion pulse
RData  out  32  load result, valid with Done, held until next Done
AddrErr  out  1  qualifies Done: request rejected, no memory access
Address  out  ADDR_W  word-aligned memory address ({ReqAddr[ADDR_W-1:2],2'b00})
writeData  out  32  merged word to memory
MemRead  out  1  memory read enable
MemWrite  out  1  memory write enable
ReadData  in  32  memory read data

Behaviour:
- Reset (synchronous) takes effect at the next rising edge from any state: state=IDLE.
- Reset values: Address=0, writeData=0, MemRead=0, MemWrite=0, Busy=0, Done=0, RData=0, AddrErr=0, RD_LAT counter=0.
- Reset mid-operation: abort the request; no MemWrite is asserted in or after the reset cycle.
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE, Req=1:
  - Latch all Req* inputs.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or ReqSize=11 -> ERR.
  - Load or sub-word store -> READ.
  - Word store -> WRITE.
- Req in any state other than IDLE is ignored (not queued).
- READ:
  - MemRead=1, Address=word address, held for RD_LAT cycles.
  - ReadData is sampled on the edge ending the last READ cycle.
  - Load: extract the lane, extend it, register it into RData -> DONE.
  - Sub-word store: merge ReqWData into the sampled word -> WRITE.
- WRITE:
  - Exactly one cycle with MemWrite=1, MemRead=0, Address=word address, writeData=merged/full word -> DONE.
- DONE: Done=1, AddrErr=0 for one cycle -> IDLE.
- ERR: Done=1, AddrErr=1 for one cycle; RData unchanged -> IDLE.
- Lanes (little-endian):
  - Byte k=addr[1:0] occupies bits [8k+7:8k].
  - Half at addr[1]=h occupies bits [16h+15:16h].
  - Store merge replaces only the addressed lane; other bits come from ReadData.
- Latency (Req accepted at edge 0):
  - Word store: Done in cycle 2.
  - Load: Done in cycle RD_LAT+1.
  - Sub-word store: Done in cycle RD_LAT+2.
  - Error: Done in cycle 1.
- Control outputs outside READ/WRITE:
  - MemRead=0, MemWrite=0.
  - Address and writeData hold their last values; the memory sees no address change between operations.
- Back-to-back: a new Req is accepted in the IDLE cycle directly after DONE/ERR.
- Busy=1 in READ, WRITE, DONE and ERR.

Optional Feature:
- Macro: DATA_MEM_MASTER_STATS_EN.
- When defined, adds output ports LdCnt (16) and StCnt (16).
  - Reset to 0.
  - Increment once per successful load/store completion (DONE state); ERR increments neither.
  - Wrap from 16'hFFFF to 0.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Word store ReqAddr=0x10, ReqWData=0xDEADBEEF -> one-cycle MemWrite with Address=0x10, writeData=0xDEADBEEF; Done in cycle 2; MemRead never asserted.
- Memory word 0x10=0x8070F0A5, signed byte load at 0x13 -> RData=0xFFFFFF80; unsigned byte load at 0x12 -> 0x00000070; signed half load at 0x10 -> 0xFFFFF0A5.
- Byte store 0x5A at 0x11 over word 0x11223344 -> READ then WRITE with writeData=0x11225A44; Done at cycle RD_LAT+2; repeat with RD_LAT=3.
- Word load at 0x22, half load at 0x33, and ReqSize=11 -> Done with AddrErr=1 in cycle 1; MemRead=MemWrite=0 throughout; RData unchanged.
- Reset asserted during READ of a half store -> next cycle all outputs at reset values; MemWrite never asserted; a following load completes normally.
- With DATA_MEM_MASTER_STATS_EN: 3 loads, 2 stores, 1 error -> LdCnt=3, StCnt=2; Req pulsed while Busy -> ignored, counts unchanged.

Source files
------------

// File: rtl/data_mem_master_if.sv
// Word-wide data-memory bus between the load/store controller (master) and the memory (slave).
interface data_mem_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] Address;
    logic [31:0]       writeData;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       ReadData;

    modport master (
        output Address,
        output writeData,
        output MemRead,
        output MemWrite,
        input  ReadData
    );

    modport slave (
        input  Address,
        input  writeData,
        input  MemRead,
        input  MemWrite,
        output ReadData
    );
endinterface

// File: rtl/data_mem_master.sv
// Multi-cycle load/store controller for a word-only data memory (read-modify-write for sub-word stores).
// Optional load/store completion counters are enabled by defining DATA_MEM_MASTER_STATS_EN.
module data_mem_master #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [31:0]       ReqWData,
    output logic              Busy,
    output logic              Done,
    output logic [31:0]       RData,
    output logic              AddrErr,
    data_mem_master_if.master mem
`ifdef DATA_MEM_MASTER_STATS_EN
    ,
    output logic [15:0]       LdCnt,
    output logic [15:0]       StCnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [31:0]       rdata_q, rdata_d;
`ifdef DATA_MEM_MASTER_STATS_EN
    logic [15:0]       ld_cnt_q, ld_cnt_d;
    logic [15:0]       st_cnt_q, st_cnt_d;
`endif

    logic        misaligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Lane extraction and store merge operate on the live ReadData, used only on the last READ cycle.
    // NOTE: every signal assigned in always_comb gets a default first; a missed path would infer a latch.
    always_comb begin
        byte_lane = mem.ReadData[{off_q, 3'b000} +: 8];
        half_lane = mem.ReadData[{off_q[1], 4'b0000} +: 16];
        load_val  = mem.ReadData;
        merged    = mem.ReadData;
        case (size_q)
            SZ_BYTE: begin
                load_val = sgn_q ? {{24{byte_lane[7]}}, byte_lane} : {24'b0, byte_lane};
                merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                load_val = sgn_q ? {{16{half_lane[15]}}, half_lane} : {16'b0, half_lane};
                merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    assign misaligned = (ReqSize == 2'b11)
                     || ((ReqSize == SZ_HALF) && ReqAddr[0])
                     || ((ReqSize == SZ_WORD) && (ReqAddr[1:0] != 2'b00));

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        address_d = address_q;
        wr_data_d = wr_data_q;
        rdata_d   = rdata_q;
`ifdef DATA_MEM_MASTER_STATS_EN
        ld_cnt_d  = ld_cnt_q;
        st_cnt_d  = st_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    write_d = ReqWrite;
                    size_d  = ReqSize;
                    sgn_d   = ReqSigned;
                    off_d   = ReqAddr[1:0];
                    wdata_d = ReqWData;
                    cnt_d   = '0;
                    if (misaligned) begin
                        state_d = S_ERR;
                    end else begin
                        // Address only moves for a real access, so the memory sees it stable otherwise.
                        address_d = {ReqAddr[ADDR_W-1:2], 2'b00};
                        if (ReqWrite && (ReqSize == SZ_WORD)) begin
                            wr_data_d = ReqWData;
                            state_d   = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                if (cnt_q == LAST_CNT) begin
                    if (write_q) begin
                        wr_data_d = merged;
                        state_d   = S_WRITE;
                    end else begin
                        rdata_d = load_val;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
`ifdef DATA_MEM_MASTER_STATS_EN
                if (write_q) st_cnt_d = st_cnt_q + 16'd1;
                else         ld_cnt_d = ld_cnt_q + 16'd1;
`endif
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            size_q    <= 2'b00;
            sgn_q     <= 1'b0;
            off_q     <= 2'b00;
            wdata_q   <= '0;
            cnt_q     <= '0;
            address_q <= '0;
            wr_data_q <= '0;
            rdata_q   <= '0;
`ifdef DATA_MEM_MASTER_STATS_EN
            ld_cnt_q  <= '0;
            st_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            size_q    <= size_d;
            sgn_q     <= sgn_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            address_q <= address_d;
            wr_data_q <= wr_data_d;
            rdata_q   <= rdata_d;
`ifdef DATA_MEM_MASTER_STATS_EN
            ld_cnt_q  <= ld_cnt_d;
            st_cnt_q  <= st_cnt_d;
`endif
        end
    end

    assign Busy          = (state_q != S_IDLE);
    assign Done          = (state_q == S_DONE) || (state_q == S_ERR);
    assign AddrErr       = (state_q == S_ERR);
    assign RData         = rdata_q;
    assign mem.Address   = address_q;
    assign mem.writeData = wr_data_q;
    assign mem.MemRead   = (state_q == S_READ);
    // A reset arriving during WRITE must suppress the write in that same cycle.
    assign mem.MemWrite  = (state_q == S_WRITE) && !Reset;
`ifdef DATA_MEM_MASTER_STATS_EN
    assign LdCnt         = ld_cnt_q;
    assign StCnt         = st_cnt_q;
`endif

endmodule
